// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the lfsr pseudo-random source.
// Tap masks are written with bit i set for each tapped state bit.
package lfsr_pkg;

    localparam int unsigned MAX_W = 32'd16;

    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hD008;

    localparam logic [MAX_W-1:0] ONE_X = 16'h0001;

    // An all-zero state is the LFSR lockup point, so it is never allowed in.
    function automatic logic [MAX_W-1:0] sanitize_seed(input logic [MAX_W-1:0] v);
        return (v == 16'h0000) ? ONE_X : v;
    endfunction

    function automatic logic lfsr_fb(input logic [MAX_W-1:0] state,
                                     input logic [MAX_W-1:0] taps);
        return ^(state & taps);
    endfunction

endpackage

// File: rtl/lfsr_if.sv
// Control and result bundle between the lfsr and its consumer.
interface lfsr_if #(
    parameter int unsigned WIDTH = 32'd8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] rnd;
    logic [WIDTH-1:0] rnd_range;
    logic [WIDTH-1:0] step_cnt;

    modport master (
        output en, load, load_value,
        input  rnd, rnd_range, step_cnt
    );

    modport slave (
        input  en, load, load_value,
        output rnd, rnd_range, step_cnt
    );
endinterface

// File: rtl/lfsr_range.sv
// Combinational range reducer: (value % RANGE) + OFFSET, truncated to WIDTH.
// Only built when LFSR_RANGE_EN is defined.
`ifdef LFSR_RANGE_EN
module lfsr_range #(
    parameter int unsigned WIDTH  = 32'd8,
    parameter int unsigned RANGE  = 32'd26,
    parameter int unsigned OFFSET = 32'h0000_0061
) (
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_value
);
    localparam logic [WIDTH-1:0] RANGE_V  = WIDTH'(RANGE);
    localparam logic [WIDTH-1:0] ONE_V    = WIDTH'(32'd1);
    // A zero modulus is rejected at elaboration; this keeps the divider defined.
    localparam logic [WIDTH-1:0] RANGE_S  = (RANGE_V == WIDTH'(32'd0)) ? ONE_V : RANGE_V;
    localparam logic [WIDTH-1:0] OFFSET_V = WIDTH'(OFFSET);

    logic [WIDTH-1:0] w_mod;

    // Unsigned modulus followed by offset; the sum wraps at WIDTH bits.
    always_comb begin
        w_mod   = i_value % RANGE_S;
        o_value = w_mod + OFFSET_V;
    end
endmodule
`endif

// File: rtl/lfsr.sv
// Fibonacci LFSR random source with step counter and optional range output.
// Macro LFSR_RANGE_EN enables rnd_range; otherwise rnd_range is tied to zero.
module lfsr
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH  = 32'd8,
    parameter int unsigned SEED   = 32'd1,
    parameter int unsigned RANGE  = 32'd26,
    parameter int unsigned OFFSET = 8'h61
) (
    input  logic  i_clk,
    input  logic  i_reset,
    lfsr_if.slave io_bus
);
    localparam logic [WIDTH-1:0] ZERO_V      = WIDTH'(32'd0);
    localparam logic [WIDTH-1:0] ONE_V       = WIDTH'(32'd1);
    localparam logic [WIDTH-1:0] SEED_T      = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] RESET_STATE = WIDTH'(sanitize_seed(MAX_W'(SEED_T)));
    localparam logic [MAX_W-1:0] W_TAPS      = (WIDTH == 32'd16) ? TAPS_W16 : MAX_W'(TAPS_W8);

    if ((WIDTH != 32'd8) && (WIDTH != 32'd16)) begin : g_bad_width
        $error("lfsr: WIDTH must be 8 or 16");
    end
    if ((RANGE < 32'd1) || (RANGE >= (32'd1 << WIDTH))) begin : g_bad_range
        $error("lfsr: RANGE must lie in 1..2^WIDTH-1");
    end
    if (OFFSET >= (32'd1 << WIDTH)) begin : g_wide_offset
        $warning("lfsr: OFFSET is wider than WIDTH, upper bits are dropped");
    end

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_state_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_fb;

    // Next state: load beats the lockup guard, which beats stepping; otherwise hold.
    always_comb begin
        w_fb        = lfsr_fb(MAX_W'(r_state), W_TAPS);
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (io_bus.load) begin
            w_state_nxt = WIDTH'(sanitize_seed(MAX_W'(io_bus.load_value)));
            w_cnt_nxt   = ZERO_V;
        end else if (r_state == ZERO_V) begin
            w_state_nxt = ONE_V;
        end else if (io_bus.en) begin
            w_state_nxt = {r_state[WIDTH-2:0], w_fb};
            w_cnt_nxt   = r_cnt + ONE_V;
        end else begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
        end
    end

    // State and step counter registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= RESET_STATE;
            r_cnt   <= ZERO_V;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign io_bus.rnd      = r_state;
    assign io_bus.step_cnt = r_cnt;

`ifdef LFSR_RANGE_EN
    lfsr_range #(
        .WIDTH  (WIDTH),
        .RANGE  (RANGE),
        .OFFSET (OFFSET)
    ) u_range (
        .i_value (r_state),
        .o_value (io_bus.rnd_range)
    );
`else
    assign io_bus.rnd_range = ZERO_V;
`endif

endmodule

// File: tb/tb_lfsr.sv
// Self-checking bench for lfsr: directed test-plan steps, then random stimulus
// compared with an arithmetic reference model.
module tb_lfsr;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        load;
    logic [15:0] lv16;

    int n_assert = 0;
    int n_fail   = 0;

    int m8;
    int c8;
    int m16;
    int c16;
    bit seen [256];

    always #5 clk = ~clk;

    lfsr_if #(.WIDTH(8))  bus8  ();
    lfsr_if #(.WIDTH(8))  bus71 ();
    lfsr_if #(.WIDTH(16)) bus16 ();

    assign bus8.en          = en;
    assign bus8.load        = load;
    assign bus8.load_value  = lv16[7:0];
    assign bus71.en         = en;
    assign bus71.load       = load;
    assign bus71.load_value = lv16[7:0];
    assign bus16.en         = en;
    assign bus16.load       = load;
    assign bus16.load_value = lv16;

    lfsr #(.WIDTH(8), .SEED(1), .RANGE(26), .OFFSET(8'h61)) u_dut8 (
        .i_clk (clk), .i_reset (reset), .io_bus (bus8)
    );
    lfsr #(.WIDTH(8), .SEED(1), .RANGE(71), .OFFSET(0)) u_dut71 (
        .i_clk (clk), .i_reset (reset), .io_bus (bus71)
    );
    lfsr #(.WIDTH(16), .SEED(16'hACE1), .RANGE(26), .OFFSET(8'h61)) u_dut16 (
        .i_clk (clk), .i_reset (reset), .io_bus (bus16)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: polynomial feedback evaluated on integers, shifted in at bit 0.
    function automatic int next8(input int s);
        int fb;
        fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
        return ((s << 1) | fb) % 256;
    endfunction

    function automatic int next16(input int s);
        int fb;
        fb = ((s >> 15) ^ (s >> 14) ^ (s >> 12) ^ (s >> 3)) & 1;
        return ((s << 1) | fb) % 65536;
    endfunction

    task automatic model_step();
        int lv8;
        int lvw;
        lv8 = int'(lv16[7:0]);
        lvw = int'(lv16);
        if (reset) begin
            m8 = 1; c8 = 0; m16 = 16'hACE1; c16 = 0;
        end else if (load) begin
            m8  = (lv8 == 0) ? 1 : lv8;  c8  = 0;
            m16 = (lvw == 0) ? 1 : lvw;  c16 = 0;
        end else if (en) begin
            m8  = next8(m8);   c8  = (c8 + 1) % 256;
            m16 = next16(m16); c16 = (c16 + 1) % 65536;
        end
    endtask

    task automatic check_all(input string tag);
        int e26;
        int e71;
        int e16;
`ifdef LFSR_RANGE_EN
        e26 = (m8 % 26 + 97) % 256;
        e71 = m8 % 71;
        e16 = (m16 % 26 + 97) % 65536;
`else
        e26 = 0;
        e71 = 0;
        e16 = 0;
`endif
        chk({tag, ":rnd8"},    16'(bus8.rnd),        16'(m8));
        chk({tag, ":cnt8"},    16'(bus8.step_cnt),   16'(c8));
        chk({tag, ":range26"}, 16'(bus8.rnd_range),  16'(e26));
        chk({tag, ":rnd71"},   16'(bus71.rnd),       16'(m8));
        chk({tag, ":range71"}, 16'(bus71.rnd_range), 16'(e71));
        chk({tag, ":rnd16"},   bus16.rnd,            16'(m16));
        chk({tag, ":cnt16"},   bus16.step_cnt,       16'(c16));
        chk({tag, ":range16"}, bus16.rnd_range,      16'(e16));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        model_step();
        check_all(tag);
    endtask

    initial begin
        logic [7:0] exp_seq [5];
        logic [7:0] v;
        exp_seq[0] = 8'h02; exp_seq[1] = 8'h04; exp_seq[2] = 8'h08;
        exp_seq[3] = 8'h11; exp_seq[4] = 8'h23;
        m8 = 0; c8 = 0; m16 = 0; c16 = 0;

        // Reset then the first steps of the sequence
        reset = 1'b1; en = 1'b1; load = 1'b0; lv16 = 16'h0000;
        tick("reset");
        chk("reset_rnd", 16'(bus8.rnd), 16'h0001);
        chk("reset_cnt", 16'(bus8.step_cnt), 16'h0000);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick("seq");
            chk("seq_const", 16'(bus8.rnd), 16'(exp_seq[i]));
        end
`ifdef LFSR_RANGE_EN
        chk("range_0x23", 16'(bus8.rnd_range), 16'h006A);
`else
        chk("range_off", 16'(bus8.rnd_range), 16'h0000);
`endif

        // Full period from reset
        reset = 1'b1;
        tick("period_reset");
        reset = 1'b0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[1] = 1'b1;
        for (int i = 0; i < 255; i++) begin
            tick("period");
            v = bus8.rnd;
            if (i < 254) begin
                chk("period_unique", {15'h0000, (v == 8'h00) || seen[v]}, 16'h0000);
                seen[v] = 1'b1;
            end
            chk("range71_bound", {15'h0000, bus71.rnd_range >= 8'd71}, 16'h0000);
        end
        chk("period_rnd", 16'(bus8.rnd), 16'h0001);
        chk("period_cnt", 16'(bus8.step_cnt), 16'h00FF);

        // Hold at 0x08
        reset = 1'b1;
        tick("hold_reset");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick("hold_pre");
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick("hold");
            chk("hold_rnd", 16'(bus8.rnd), 16'h0008);
            chk("hold_cnt", 16'(bus8.step_cnt), 16'h0003);
        end
        en = 1'b1;
        tick("hold_resume");
        chk("hold_resume_rnd", 16'(bus8.rnd), 16'h0011);

        // Load zero and a real seed, load beating en
        load = 1'b1; lv16 = 16'h0000;
        tick("load_zero");
        chk("load_zero_rnd", 16'(bus8.rnd), 16'h0001);
        chk("load_zero_cnt", 16'(bus8.step_cnt), 16'h0000);
        lv16 = 16'h005A;
        tick("load_5a");
        chk("load_5a_rnd", 16'(bus8.rnd), 16'h005A);
        load = 1'b0;
        tick("load_step");
        chk("load_step_rnd", 16'(bus8.rnd), 16'h00B4);

        // Reset mid-run wins over load and en
        reset = 1'b1;
        tick("mid_reset0");
        reset = 1'b0;
        for (int i = 0; i < 37; i++) tick("mid_run");
        reset = 1'b1; load = 1'b1; lv16 = 16'h0077;
        tick("mid_reset");
        chk("mid_reset_rnd", 16'(bus8.rnd), 16'h0001);
        chk("mid_reset_cnt", 16'(bus8.step_cnt), 16'h0000);
        reset = 1'b0; load = 1'b0;

        // Randomised control against the model
        for (int i = 0; i < 400; i++) begin
            int r;
            r     = int'($urandom_range(0, 99));
            reset = (r < 2);
            load  = (r >= 2) && (r < 8);
            en    = ($urandom_range(0, 3) != 0);
            lv16  = 16'($urandom);
            if ($urandom_range(0, 9) == 0) lv16 = 16'h0000;
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/lfsr.md
Name: lfsr

Overview:
- Free-running 8-bit (parameterisable) Fibonacci LFSR pseudo-random source for the typing-game datapath.
- Steps once per enabled clock.
- Drives the raw random value plus a range-reduced value; for example, the value is mapped to a letter code ('a'..'z') or to a column index.
- Several instances run from different clocks to decorrelate the streams.

Parameters:
- WIDTH, 8, state/output width in bits; supported values 8 and 16.
- SEED, 1, reset value of the state; a SEED of 0 is replaced by 1.
- RANGE, 26, modulus for the range-reduced output; must be 1..2^WIDTH-1.
- OFFSET, 8'h61, value added after the modulus.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  step enable; tied to 1 for free-run.
- load  in  1  synchronous seed load.
- load_value  in  WIDTH  seed to load.
- rnd  out  WIDTH  current LFSR state (registered).
- rnd_range  out  WIDTH  (rnd % RANGE) + OFFSET, truncated to WIDTH.
- step_cnt  out  WIDTH  number of steps since reset/load, wrapping.

Behaviour:
- Reset (synchronous, active-high): state = SEED (or 1 if SEED==0); step_cnt = 0; rnd_range reflects the reset state on the same cycle the state updates.
- Priority each rising edge: reset > load > en > hold.
- load=1: state = load_value, or 1 if load_value==0; step_cnt = 0.
- en=1 for WIDTH=8: feedback fb = rnd[7]^rnd[5]^rnd[4]^rnd[3] (polynomial x^8+x^6+x^5+x^4+1); next state = {rnd[6:0], fb}; step_cnt += 1, wrapping at 2^WIDTH.
- en=1 for WIDTH=16: taps 16,15,13,4; fb = rnd[15]^rnd[14]^rnd[12]^rnd[3]; shift left as above.
- en=0: state and step_cnt hold.
- Period: 2^WIDTH-1, i.e. 255 for WIDTH=8. State is never 0.
- Lockup guard: if state ever reads 0 (e.g. after an upset), the next edge forces it to 1 regardless of en.
- rnd_range: combinational from the state register; unsigned modulus, then add OFFSET, result truncated to WIDTH.
- Latency: new rnd visible one clock after the enabling edge; rnd_range valid in the same cycle as rnd.
- Simultaneous reset and load: reset wins. Simultaneous load and en: load wins; no step that cycle.

Optional Feature:
- Macro LFSR_RANGE_EN.
- Defined: rnd_range = (rnd % RANGE) + OFFSET as above.
- Not defined: the modulus logic is omitted and rnd_range is driven constant 0; all other behaviour is unchanged.

Decomposition:
- Shared package lfsr_pkg holds:
  - tap-mask constants TAPS_W8 = 8'hB8 and TAPS_W16 = 16'hD008;
  - the seed-sanitise function (zero becomes 1).
- One natural sub-module: lfsr_range (modulus + offset combinational reducer), instantiated only under LFSR_RANGE_EN.

Test Plan:
- Reset with SEED=1, en=1: rnd sequence 01, 02, 04, 08, 11, 23 on successive edges; rnd_range (RANGE 26, OFFSET 0x61) after 0x23 equals 0x6A.
- Period: from reset, en=1 for 255 edges -> rnd returns to 0x01, with no repeat and no 0x00 earlier; step_cnt = 0xFF.
- Hold: en=0 for 10 cycles at rnd=0x08 -> rnd stays 0x08 and step_cnt unchanged; reasserting en -> next rnd 0x11.
- Load: load=1, load_value=0x00, with en=1 the same cycle -> rnd=0x01 and step_cnt=0; load_value=0x5A -> rnd=0x5A, then next step 0xB4.
- Reset mid-run: after 37 steps, assert reset with en=1 and load=1 -> rnd=0x01 and step_cnt=0 on that edge.
- Range: RANGE=71, OFFSET=0 -> for all 255 states rnd_range < 71; with LFSR_RANGE_EN undefined, rnd_range=0 throughout.
